// File: rtl/dc_fu_line_scheduler.sv
// Per-frame line request sequencer feeding the lines translator.
// Walks source lines once per frame, repeating each line vscale times, paced by translator ready and line-buffer credits.
module dc_fu_line_scheduler #(
  parameter int AXI_ARADDR_WIDTH      = 32,
  parameter int PIXELS_PER_LINE_WIDTH = 8,
  parameter int LINE_NUMBER_WIDTH     = 8,
  parameter int VSCALE_WIDTH          = 4,
  parameter int CREDIT_WIDTH          = 2,
  parameter int MAX_CREDITS           = 2
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic                             frame_start,
  input  logic [AXI_ARADDR_WIDTH-1:0]      frame_addr_in,
  input  logic [PIXELS_PER_LINE_WIDTH-1:0] ppl_in,
  input  logic [LINE_NUMBER_WIDTH-1:0]     lines_in,
  input  logic [VSCALE_WIDTH-1:0]          vscale_in,
  input  logic                             line_done,
  output logic [AXI_ARADDR_WIDTH-1:0]      frame_addr,
  output logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
  output logic [LINE_NUMBER_WIDTH-1:0]     line_number,
  output logic                             line_data_valid,
  input  logic                             line_data_ready,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun
);

  // state | meaning
  // IDLE  | waiting for frame_start
  // ARM   | waiting for translator ready and a free line slot
  // ACK   | request valid, waiting for translator to go busy
  // DONE  | frame_done pulse; a new frame_start is accepted here too
  typedef enum logic [1:0] {IDLE, ARM, ACK, DONE} state_t;

  localparam logic [CREDIT_WIDTH-1:0] CREDITS_FULL = CREDIT_WIDTH'(MAX_CREDITS);

  state_t state, state_n;

  logic [AXI_ARADDR_WIDTH-1:0]      frame_addr_q;
  logic [PIXELS_PER_LINE_WIDTH-1:0] ppl_q;
  logic [LINE_NUMBER_WIDTH-1:0]     lines_q;
  logic [VSCALE_WIDTH-1:0]          vscale_q;
  logic [LINE_NUMBER_WIDTH-1:0]     src_line;
  logic [VSCALE_WIDTH-1:0]          rep;
  logic [CREDIT_WIDTH-1:0]          credits;
  logic                             valid_q;
  logic                             busy_q;
  logic                             done_q;
  logic                             overrun_q;

  logic                  start_ok;
  logic                  issue;
  logic                  advance;
  logic                  last_rep;
  logic                  last_line;
  logic [VSCALE_WIDTH:0] rep_inc;

  always_comb begin
    state_n   = state;
    start_ok  = frame_start && ((state == IDLE) || (state == DONE));
    issue     = (state == ARM) && line_data_ready && (credits != '0);
    // translator drops ready the cycle after it takes the request
    advance   = (state == ACK) && !line_data_ready;
    rep_inc   = {1'b0, rep} + (VSCALE_WIDTH + 1)'(1);
    last_rep  = rep_inc >= {1'b0, vscale_q};
    last_line = src_line == (lines_q - LINE_NUMBER_WIDTH'(1));

    case (state)
      IDLE, DONE: begin
        if (start_ok) state_n = (lines_in == '0) ? DONE : ARM;
        else          state_n = IDLE;
      end
      ARM: begin
        if (issue) state_n = ACK;
      end
      ACK: begin
        if (advance) state_n = (last_rep && last_line) ? DONE : ARM;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      frame_addr_q <= '0;
      ppl_q        <= '0;
      lines_q      <= '0;
      vscale_q     <= '0;
      src_line     <= '0;
      rep          <= '0;
      credits      <= CREDITS_FULL;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (en) begin
      state   <= state_n;
      valid_q <= (state_n == ACK);
      busy_q  <= (state_n == ARM) || (state_n == ACK);
      done_q  <= (state_n == DONE);

      if (start_ok) begin
        frame_addr_q <= frame_addr_in;
        ppl_q        <= ppl_in;
        lines_q      <= lines_in;
        vscale_q     <= (vscale_in == '0) ? VSCALE_WIDTH'(1) : vscale_in;
        src_line     <= '0;
        rep          <= '0;
      end else if (advance) begin
        if (!last_rep) begin
          rep <= rep + VSCALE_WIDTH'(1);
        end else begin
          rep      <= '0;
          src_line <= src_line + LINE_NUMBER_WIDTH'(1);
        end
      end

      if (frame_start && ((state == ARM) || (state == ACK))) overrun_q <= 1'b1;

      // issue and return in the same cycle cancel out
      if (issue && !line_done) begin
        credits <= credits - CREDIT_WIDTH'(1);
      end else if (!issue && line_done && (credits != CREDITS_FULL)) begin
        credits <= credits + CREDIT_WIDTH'(1);
      end
    end
  end

  assign frame_addr      = frame_addr_q;
  assign pixels_per_line = ppl_q;
  assign line_number     = src_line;
  assign line_data_valid = valid_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign overrun         = overrun_q;

endmodule
